// File: rtl/fig8_drive_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fig8_drive_sequencer
//  Purpose  : Drives a Roomba-style OI robot through a figure-8 pattern by
//             streaming Start/Full, left-arc, right-arc and stop drive packets
//             to a UART transmitter, holding each arc for SEG_TICKS cycles.
//  Ports    : clk        - system clock, rising edge
//             reset      - synchronous active-high reset
//             go         - start request (acted on in IDLE only)
//             halt       - abort request
//             laps       - number of figure-8 laps, latched on accepted go
//             tx_busy    - UART transmitter busy flag
//             tx_data    - byte to transmit, held until the next tx_start
//             tx_start   - one-cycle transmit request
//             busy       - high whenever not IDLE
//             done       - one-cycle pulse when the stop packet completes
//             state_dbg  - current state code
//  Revision : 1.0  initial release
// ============================================================================
module fig8_drive_sequencer #(
  parameter logic [31:0] SEG_TICKS = 32'd50_000_000,
  parameter logic [15:0] VELOCITY  = 16'h00C8,
  parameter logic [15:0] RADIUS    = 16'h01F4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       halt,
  input  logic [3:0] laps,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INIT      = 3'd1,
    ST_SEND_L    = 3'd2,
    ST_WAIT_L    = 3'd3,
    ST_SEND_R    = 3'd4,
    ST_WAIT_R    = 3'd5,
    ST_SEND_STOP = 3'd6
  } state_t;

  // Two's complement negation wraps modulo 2^16 (16'h8000 maps to itself).
  localparam logic [15:0] C_NEG_RADIUS = (~RADIUS) + 16'd1;
  localparam logic [31:0] C_WAIT_LOAD  = SEG_TICKS - 32'd1;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;          // index of the byte issued / to issue
  logic        out_q, out_d;          // a byte of this packet has been issued
  logic        nolook_q;              // cycle after tx_start: ignore tx_busy
  logic [3:0]  lap_q, lap_d;
  logic [31:0] timer_q, timer_d;
  logic        halt_lat_q, halt_lat_d;
  logic [7:0]  tx_data_q;

  logic        is_send;
  logic        pkt_done;
  logic        halt_eff;
  logic [2:0]  last_idx;
  logic [2:0]  issue_idx;
  logic [15:0] vel_w, rad_w;
  logic [7:0]  byte_w;

  // --------------------------------------------------------------------------
  // Packet byte selection
  // --------------------------------------------------------------------------
  always_comb begin
    vel_w = VELOCITY;
    rad_w = RADIUS;
    if (state_q == ST_SEND_R) begin
      rad_w = C_NEG_RADIUS;
    end else if (state_q == ST_SEND_STOP) begin
      vel_w = 16'h0000;
      rad_w = 16'h0000;
    end
  end

  // When a byte is already outstanding the next one issued is idx_q+1.
  assign issue_idx = out_q ? 3'(idx_q + 3'd1) : idx_q;

  always_comb begin
    byte_w = 8'h00;
    if (state_q == ST_INIT) begin
      byte_w = issue_idx[0] ? 8'h84 : 8'h80;
    end else begin
      case (issue_idx)
        3'd0:    byte_w = 8'h89;
        3'd1:    byte_w = vel_w[15:8];
        3'd2:    byte_w = vel_w[7:0];
        3'd3:    byte_w = rad_w[15:8];
        3'd4:    byte_w = rad_w[7:0];
        default: byte_w = 8'h00;
      endcase
    end
  end

  assign is_send  = (state_q == ST_INIT)   || (state_q == ST_SEND_L) ||
                    (state_q == ST_SEND_R) || (state_q == ST_SEND_STOP);
  assign last_idx = (state_q == ST_INIT) ? 3'd1 : 3'd4;
  assign halt_eff = halt_lat_q | halt;

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    out_d      = out_q;
    lap_d      = lap_q;
    timer_d    = timer_q;
    halt_lat_d = halt_lat_q;
    tx_start   = 1'b0;
    done       = 1'b0;
    pkt_done   = 1'b0;

    // Byte handshake: a low tx_busy outside the no-look cycle either means
    // the transmitter is free for the first byte or the previous byte ended.
    if (is_send && !nolook_q && !tx_busy) begin
      if (!out_q) begin
        tx_start = 1'b1;
        out_d    = 1'b1;
      end else if (idx_q != last_idx) begin
        tx_start = 1'b1;
        idx_d    = 3'(idx_q + 3'd1);
      end else begin
        pkt_done = 1'b1;
      end
    end

    // Halt during a drive packet is deferred until the packet is complete.
    if ((state_q == ST_INIT || state_q == ST_SEND_L || state_q == ST_SEND_R) && halt) begin
      halt_lat_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (go && !halt && (laps != 4'd0)) begin
          state_d = ST_INIT;
          lap_d   = laps;
        end
      end
      ST_INIT: begin
        if (pkt_done) state_d = halt_eff ? ST_SEND_STOP : ST_SEND_L;
      end
      ST_SEND_L: begin
        if (pkt_done) begin
          state_d = halt_eff ? ST_SEND_STOP : ST_WAIT_L;
          timer_d = C_WAIT_LOAD;
        end
      end
      ST_SEND_R: begin
        if (pkt_done) begin
          state_d = halt_eff ? ST_SEND_STOP : ST_WAIT_R;
          timer_d = C_WAIT_LOAD;
        end
      end
      ST_WAIT_L: begin
        if (halt) begin
          state_d = ST_SEND_STOP;
        end else if (timer_q == 32'd0) begin
          state_d = ST_SEND_R;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      ST_WAIT_R: begin
        if (halt) begin
          state_d = ST_SEND_STOP;
        end else if (timer_q == 32'd0) begin
          lap_d   = lap_q - 4'd1;
          state_d = (lap_q > 4'd1) ? ST_SEND_L : ST_SEND_STOP;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      ST_SEND_STOP: begin
        if (pkt_done) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      idx_d = 3'd0;
      out_d = 1'b0;
      if (state_d == ST_SEND_STOP) halt_lat_d = 1'b0;
    end
  end

  // tx_data presents the new byte combinationally in the tx_start cycle and
  // the register holds it afterwards.
  assign tx_data   = tx_start ? byte_w : tx_data_q;
  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= 3'd0;
      out_q      <= 1'b0;
      nolook_q   <= 1'b0;
      lap_q      <= 4'd0;
      timer_q    <= 32'd0;
      halt_lat_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      out_q      <= out_d;
      nolook_q   <= tx_start;
      lap_q      <= lap_d;
      timer_q    <= timer_d;
      halt_lat_q <= halt_lat_d;
      tx_data_q  <= tx_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fig8_drive_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fig8_drive_sequencer
//  Purpose  : Directed self-checking bench for fig8_drive_sequencer with
//             SEG_TICKS=20 and a transmitter model busy for 10 cycles.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fig8_drive_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       go = 1'b0;
  logic       halt = 1'b0;
  logic [3:0] laps = 4'd0;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       done;
  logic [2:0] state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  fig8_drive_sequencer #(
    .SEG_TICKS(32'd20),
    .VELOCITY (16'h00C8),
    .RADIUS   (16'h01F4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .go       (go),
    .halt     (halt),
    .laps     (laps),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .busy     (busy),
    .done     (done),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy for the 10 cycles following a tx_start.
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // Monitor: captured bytes, done pulses, WAIT run lengths, rule violations.
  logic [7:0] got_q[$];
  int         runs_q[$];
  int         done_cnt = 0;
  int         viol = 0;
  int         run_len = 0;
  always @(negedge clk) begin
    if (tx_start) got_q.push_back(tx_data);
    if (done) done_cnt++;
    if (tx_start && (state_dbg == 3'd0 || done)) viol++;
    if (state_dbg == 3'd3 || state_dbg == 3'd5) begin
      run_len++;
    end else if (run_len != 0) begin
      runs_q.push_back(run_len);
      run_len = 0;
    end
  end

  logic [7:0] exp_q[$];

  task automatic push_pkt(input logic [7:0] b0, b1, b2, b3, b4);
    exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2);
    exp_q.push_back(b3); exp_q.push_back(b4);
  endtask
  task automatic push_init();  exp_q.push_back(8'h80); exp_q.push_back(8'h84); endtask
  task automatic push_left();  push_pkt(8'h89, 8'h00, 8'hC8, 8'h01, 8'hF4); endtask
  task automatic push_right(); push_pkt(8'h89, 8'h00, 8'hC8, 8'hFE, 8'h0C); endtask
  task automatic push_stop();  push_pkt(8'h89, 8'h00, 8'h00, 8'h00, 8'h00); endtask

  task automatic pulse_go(input logic [3:0] l, input logic h);
    @(negedge clk); go = 1'b1; laps = l; halt = h;
    @(negedge clk); go = 1'b0; halt = 1'b0;
  endtask

  task automatic wait_done(input int base, output bit ok);
    int n = 0;
    while (done_cnt == base && n < 5000) begin @(negedge clk); n++; end
    ok = (done_cnt != base);
  endtask

  task automatic wait_state(input logic [2:0] code, output bit ok);
    int n = 0;
    while (state_dbg !== code && n < 5000) begin @(negedge clk); n++; end
    ok = (state_dbg === code);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
    n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_one_lap();
    int base = got_q.size();
    int dbase = done_cnt;
    bit ok;
    exp_q.delete(); push_init(); push_left(); push_right(); push_stop();
    pulse_go(4'd1, 1'b0);
    wait_done(dbase, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL one_lap_timeout got=no_done exp=done"); end
    repeat (3) @(negedge clk);
    n_cmp++; if (got_q.size() - base != 17) begin n_fail++; $display("FAIL one_lap_count got=%0d exp=17", got_q.size() - base); end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      n_cmp++; if (got_q[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL one_lap_byte%0d got=%h exp=%h", i, got_q[base+i], exp_q[i]); end
    end
    n_cmp++; if (done_cnt - dbase != 1) begin n_fail++; $display("FAIL one_lap_done got=%0d exp=1", done_cnt - dbase); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL one_lap_busy got=%b exp=0", busy); end
  endtask

  task automatic test_two_laps();
    int base = got_q.size();
    int rbase = runs_q.size();
    int dbase = done_cnt;
    bit ok;
    exp_q.delete(); push_init(); push_left(); push_right(); push_left(); push_right(); push_stop();
    pulse_go(4'd2, 1'b0);
    wait_done(dbase, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL two_laps_timeout got=no_done exp=done"); end
    repeat (3) @(negedge clk);
    n_cmp++; if (got_q.size() - base != 27) begin n_fail++; $display("FAIL two_laps_count got=%0d exp=27", got_q.size() - base); end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      n_cmp++; if (got_q[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL two_laps_byte%0d got=%h exp=%h", i, got_q[base+i], exp_q[i]); end
    end
    n_cmp++; if (runs_q.size() - rbase != 4) begin n_fail++; $display("FAIL two_laps_waits got=%0d exp=4", runs_q.size() - rbase); end
    for (int i = rbase; i < runs_q.size(); i++) begin
      n_cmp++; if (runs_q[i] != 20) begin n_fail++; $display("FAIL two_laps_wait_len got=%0d exp=20", runs_q[i]); end
    end
  endtask

  task automatic test_halt_wait();
    int base = got_q.size();
    int rbase = runs_q.size();
    int dbase = done_cnt;
    bit ok;
    exp_q.delete(); push_init(); push_left(); push_stop();
    pulse_go(4'd2, 1'b0);
    wait_state(3'd3, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL halt_wait_enter got=%0d exp=3", state_dbg); end
    repeat (4) @(negedge clk);
    halt = 1'b1;
    @(negedge clk); halt = 1'b0;
    n_cmp++; if (state_dbg !== 3'd6) begin n_fail++; $display("FAIL halt_wait_next got=%0d exp=6", state_dbg); end
    wait_done(dbase, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL halt_wait_timeout got=no_done exp=done"); end
    repeat (3) @(negedge clk);
    n_cmp++; if (got_q.size() - base != 12) begin n_fail++; $display("FAIL halt_wait_count got=%0d exp=12", got_q.size() - base); end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      n_cmp++; if (got_q[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL halt_wait_byte%0d got=%h exp=%h", i, got_q[base+i], exp_q[i]); end
    end
    n_cmp++; if (runs_q.size() - rbase != 1 || runs_q[runs_q.size()-1] != 5) begin
      n_fail++; $display("FAIL halt_wait_len got=%0d runs, last=%0d exp=1 run of 5", runs_q.size() - rbase, runs_q[runs_q.size()-1]);
    end
  endtask

  task automatic test_halt_send_r();
    int base = got_q.size();
    int rbase = runs_q.size();
    int dbase = done_cnt;
    int n = 0;
    bit ok;
    exp_q.delete(); push_init(); push_left(); push_right(); push_stop();
    pulse_go(4'd2, 1'b0);
    // Third byte of the right-arc packet is overall byte 10.
    while (got_q.size() - base < 10 && n < 5000) begin @(negedge clk); n++; end
    n_cmp++; if (got_q.size() - base < 10) begin n_fail++; $display("FAIL halt_r_reach got=%0d exp=10", got_q.size() - base); end
    halt = 1'b1;
    @(negedge clk); halt = 1'b0;
    wait_done(dbase, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL halt_r_timeout got=no_done exp=done"); end
    repeat (3) @(negedge clk);
    n_cmp++; if (got_q.size() - base != 17) begin n_fail++; $display("FAIL halt_r_count got=%0d exp=17", got_q.size() - base); end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      n_cmp++; if (got_q[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL halt_r_byte%0d got=%h exp=%h", i, got_q[base+i], exp_q[i]); end
    end
    n_cmp++; if (runs_q.size() - rbase != 1) begin n_fail++; $display("FAIL halt_r_waits got=%0d exp=1", runs_q.size() - rbase); end
  endtask

  task automatic test_ignored_go();
    int base = got_q.size();
    int dbase = done_cnt;
    bit ok;
    pulse_go(4'd0, 1'b0);
    pulse_go(4'd1, 1'b1);
    repeat (30) @(negedge clk);
    n_cmp++; if (got_q.size() != base) begin n_fail++; $display("FAIL ignore_go_tx got=%0d exp=0", got_q.size() - base); end
    n_cmp++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL ignore_go_state got=%0d exp=0", state_dbg); end
    pulse_go(4'd1, 1'b0);
    wait_state(3'd2, ok);
    pulse_go(4'd3, 1'b0);
    wait_done(dbase, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL ignore_go_timeout got=no_done exp=done"); end
    repeat (40) @(negedge clk);
    n_cmp++; if (got_q.size() - base != 17) begin n_fail++; $display("FAIL ignore_go_count got=%0d exp=17", got_q.size() - base); end
    n_cmp++; if (done_cnt - dbase != 1) begin n_fail++; $display("FAIL ignore_go_done got=%0d exp=1", done_cnt - dbase); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_go_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_wait_r();
    int base;
    bit ok;
    pulse_go(4'd2, 1'b0);
    wait_state(3'd5, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL rst_wr_enter got=%0d exp=5", state_dbg); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    base = got_q.size();
    n_cmp++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL rst_wr_state got=%0d exp=0", state_dbg); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_wr_busy got=%b exp=0", busy); end
    n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_wr_tx_data got=%h exp=00", tx_data); end
    n_cmp++; if (tx_start !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_wr_pulses got=%b%b exp=00", tx_start, done); end
    repeat (40) @(negedge clk);
    n_cmp++; if (got_q.size() != base) begin n_fail++; $display("FAIL rst_wr_quiet got=%0d exp=0", got_q.size() - base); end
  endtask

  initial begin
    test_reset();
    test_one_lap();
    test_two_laps();
    test_halt_wait();
    test_halt_send_r();
    test_ignored_go();
    test_reset_wait_r();
    n_cmp++; if (viol != 0) begin n_fail++; $display("FAIL tx_start_rules got=%0d exp=0", viol); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
